// File: rtl/mt_regfile_banked.sv
// ---------------------------------------------------------------------------
// mt_regfile_banked
//   Multithreaded register file with one bank of 2**REGFILE_ADDR_WIDTH
//   registers per hardware thread. Two combinational read ports, one write
//   port and an action-injection port. The action port writes an action word
//   and a mask word into two fixed registers of the target thread.
//   After reset, or on clear_req, a hardware sweep zeroes every entry.
//   An action that collides with a same-cycle write is held in a one-entry
//   pending buffer. It retires on the first cycle with wena low.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   clear_req                    restart the clear sweep (READY only)
//   init_done                    sweep finished, file usable
//   rd_thread_in, R1/R2_addr_in  read thread and indices
//   R1_data_out, R2_data_out     combinational read data
//   wena, WR_thread_in,
//   WR_addr_in, WR_data_in       write port
//   action_valid, action_ready,
//   action_thread_id_in,
//   action_data_in               action handshake and payload
//
// Configuration
//   READ_BYPASS_EN  when defined, reads in READY that hit an active write
//                   return the data being written.
// ---------------------------------------------------------------------------
module mt_regfile_banked #(
  parameter int DATAPATH_WIDTH     = 64,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int THREAD_BITS        = 2,
  parameter int NUM_ACTIONS        = 8,
  parameter int ACTION_REG         = 7,
  parameter int MASK_REG           = 6
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear_req,
  output logic                          init_done,
  input  logic [THREAD_BITS-1:0]        rd_thread_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] R1_addr_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] R2_addr_in,
  output logic [DATAPATH_WIDTH-1:0]     R1_data_out,
  output logic [DATAPATH_WIDTH-1:0]     R2_data_out,
  input  logic                          wena,
  input  logic [THREAD_BITS-1:0]        WR_thread_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
  input  logic [DATAPATH_WIDTH-1:0]     WR_data_in,
  input  logic                          action_valid,
  output logic                          action_ready,
  input  logic [THREAD_BITS-1:0]        action_thread_id_in,
  input  logic [NUM_ACTIONS-1:0]        action_data_in
);

  localparam int DW    = DATAPATH_WIDTH;
  localparam int RA    = REGFILE_ADDR_WIDTH;
  localparam int IW    = THREAD_BITS + REGFILE_ADDR_WIDTH;
  localparam int DEPTH = 1 << IW;
  localparam logic [RA-1:0] ACT_IDX  = RA'(ACTION_REG);
  localparam logic [RA-1:0] MASK_IDX = RA'(MASK_REG);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  // Action vector placed at bits [DW-9 -: NA], everything else zero.
  function automatic logic [DW-1:0] act_word(input logic [NUM_ACTIONS-1:0] a);
    logic [DW-1:0] w;
    w = '0;
    w[DW-9 -: NUM_ACTIONS] = a;
    return w;
  endfunction

  state_e                   state_q;
  logic [IW-1:0]            cnt_q;
  logic                     init_done_q;
  logic                     action_ready_q;
  logic                     pend_q;
  logic [THREAD_BITS-1:0]   pend_thr_q;
  logic [NUM_ACTIONS-1:0]   pend_data_q;
  logic [DW-1:0]            mem_q [DEPTH];

  logic                     ready_st_s;
  logic                     accept_s;
  logic                     retire_s;
  logic                     direct_s;
  logic [THREAD_BITS-1:0]   act_thr_s;
  logic [NUM_ACTIONS-1:0]   act_data_s;
  logic                     we_a_s;
  logic [IW-1:0]            addr_a_s;
  logic [DW-1:0]            data_a_s;
  logic                     we_b_s;
  logic [IW-1:0]            addr_b_s;
  logic [DW-1:0]            data_b_s;
  logic [IW-1:0]            rd1_idx_s;
  logic [IW-1:0]            rd2_idx_s;
  logic [DW-1:0]            r1_s;
  logic [DW-1:0]            r2_s;

  assign ready_st_s = (state_q == S_READY);
  // action_ready_q is only ever set in READY, so no extra state qualifier.
  assign accept_s   = action_valid && action_ready_q;
  assign retire_s   = ready_st_s && pend_q && !wena;
  assign direct_s   = ready_st_s && accept_s && !wena && !pend_q;
  assign act_thr_s  = pend_q ? pend_thr_q  : action_thread_id_in;
  assign act_data_s = pend_q ? pend_data_q : action_data_in;
  assign rd1_idx_s  = {rd_thread_in, R1_addr_in};
  assign rd2_idx_s  = {rd_thread_in, R2_addr_in};

  // Write-port arbitration: sweep, then wena, then action (pending first).
  always_comb begin
    we_a_s   = 1'b0;
    addr_a_s = '0;
    data_a_s = '0;
    we_b_s   = 1'b0;
    addr_b_s = '0;
    data_b_s = '0;
    if (!ready_st_s) begin
      we_a_s   = 1'b1;
      addr_a_s = cnt_q;
      data_a_s = '0;
    end else if (wena) begin
      we_a_s   = 1'b1;
      addr_a_s = {WR_thread_in, WR_addr_in};
      data_a_s = WR_data_in;
    end else if (retire_s || direct_s) begin
      we_a_s   = 1'b1;
      addr_a_s = {act_thr_s, ACT_IDX};
      data_a_s = act_word(act_data_s);
      we_b_s   = 1'b1;
      addr_b_s = {act_thr_s, MASK_IDX};
      data_b_s = ~act_word({NUM_ACTIONS{1'b1}});
    end else begin
      we_a_s   = 1'b0;
      we_b_s   = 1'b0;
    end
  end

  // Storage array; contents are only ever cleared by the sweep.
  always_ff @(posedge clk) begin
    if (we_a_s) begin
      mem_q[addr_a_s] <= data_a_s;
    end
    if (we_b_s) begin
      mem_q[addr_b_s] <= data_b_s;
    end
  end

  // Read ports, optionally forwarding the data being written this cycle.
  always_comb begin
    r1_s = mem_q[rd1_idx_s];
    r2_s = mem_q[rd2_idx_s];
`ifdef READ_BYPASS_EN
    if (ready_st_s && we_a_s && (addr_a_s == rd1_idx_s)) begin
      r1_s = data_a_s;
    end else if (ready_st_s && we_b_s && (addr_b_s == rd1_idx_s)) begin
      r1_s = data_b_s;
    end else begin
      r1_s = mem_q[rd1_idx_s];
    end
    if (ready_st_s && we_a_s && (addr_a_s == rd2_idx_s)) begin
      r2_s = data_a_s;
    end else if (ready_st_s && we_b_s && (addr_b_s == rd2_idx_s)) begin
      r2_s = data_b_s;
    end else begin
      r2_s = mem_q[rd2_idx_s];
    end
`endif
  end

  assign R1_data_out  = r1_s;
  assign R2_data_out  = r2_s;
  assign init_done    = init_done_q;
  assign action_ready = action_ready_q;

  // Control FSM: sweep counter, handshake outputs and pending buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_CLEAR;
      cnt_q          <= '0;
      init_done_q    <= 1'b0;
      action_ready_q <= 1'b0;
      pend_q         <= 1'b0;
      pend_thr_q     <= '0;
      pend_data_q    <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (cnt_q == {IW{1'b1}}) begin
            state_q        <= S_READY;
            cnt_q          <= '0;
            init_done_q    <= 1'b1;
            action_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        S_READY: begin
          if (clear_req) begin
            state_q        <= S_CLEAR;
            cnt_q          <= '0;
            init_done_q    <= 1'b0;
            action_ready_q <= 1'b0;
            pend_q         <= 1'b0;
          end else if (accept_s && wena) begin
            // Write port busy: park the action until wena drops.
            pend_q         <= 1'b1;
            pend_thr_q     <= action_thread_id_in;
            pend_data_q    <= action_data_in;
            action_ready_q <= 1'b0;
          end else if (retire_s) begin
            pend_q         <= 1'b0;
            action_ready_q <= 1'b1;
          end else begin
            action_ready_q <= !pend_q;
          end
        end
        default: begin
          state_q        <= S_CLEAR;
          cnt_q          <= '0;
          init_done_q    <= 1'b0;
          action_ready_q <= 1'b0;
          pend_q         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mt_regfile_banked.sv
module tb_mt_regfile_banked;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear_req;
  logic        init_done;
  logic [1:0]  rd_thread_in;
  logic [4:0]  R1_addr_in;
  logic [4:0]  R2_addr_in;
  logic [63:0] R1_data_out;
  logic [63:0] R2_data_out;
  logic        wena;
  logic [1:0]  WR_thread_in;
  logic [4:0]  WR_addr_in;
  logic [63:0] WR_data_in;
  logic        action_valid;
  logic        action_ready;
  logic [1:0]  action_thread_id_in;
  logic [7:0]  action_data_in;

  always #5 clk = ~clk;

  mt_regfile_banked dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .clear_req           (clear_req),
    .init_done           (init_done),
    .rd_thread_in        (rd_thread_in),
    .R1_addr_in          (R1_addr_in),
    .R2_addr_in          (R2_addr_in),
    .R1_data_out         (R1_data_out),
    .R2_data_out         (R2_data_out),
    .wena                (wena),
    .WR_thread_in        (WR_thread_in),
    .WR_addr_in          (WR_addr_in),
    .WR_data_in          (WR_data_in),
    .action_valid        (action_valid),
    .action_ready        (action_ready),
    .action_thread_id_in (action_thread_id_in),
    .action_data_in      (action_data_in)
  );

  typedef struct {
    int          ph;
    logic        chk;
    logic [63:0] e1;
    logic [63:0] e2;
    logic        ei;
    logic        er;
  } exp_t;

  typedef struct {
    int         t;
    logic [7:0] d;
  } act_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model: what the register file holds during the current cycle.
  logic [63:0] m_mem [128];
  bit          m_init;
  bit          m_rdy;
  int          m_cnt;
  act_t        m_pend[$];

  function automatic logic [63:0] aw(input logic [7:0] d);
    logic [63:0] w;
    w = {56'h0, d};
    return w << 48;
  endfunction

  function automatic logic [63:0] mw();
    logic [63:0] w;
    w = {56'h0, 8'hFF};
    return ~(w << 48);
  endfunction

  function automatic logic [63:0] m_read(input int idx);
    logic [63:0] v;
    v = m_mem[idx];
`ifdef READ_BYPASS_EN
    if (m_init) begin
      if (wena && idx == int'(WR_thread_in) * 32 + int'(WR_addr_in)) begin
        v = WR_data_in;
      end else if (!wena && (m_pend.size() > 0 || (action_valid && m_rdy))) begin
        int t;
        logic [7:0] d;
        if (m_pend.size() > 0) begin
          t = m_pend[0].t;
          d = m_pend[0].d;
        end else begin
          t = int'(action_thread_id_in);
          d = action_data_in;
        end
        if (idx == t * 32 + 7) v = aw(d);
        if (idx == t * 32 + 6) v = mw();
      end
    end
`endif
    return v;
  endfunction

  task automatic m_write_action(input int t, input logic [7:0] d);
    m_mem[t * 32 + 7] = aw(d);
    m_mem[t * 32 + 6] = mw();
  endtask

  // Advance the model across one posedge using the currently driven inputs.
  task automatic model_edge();
    bit   acc;
    act_t a;
    if (!m_init) begin
      m_mem[m_cnt] = 64'h0;
      if (m_cnt == 127) begin
        m_init = 1'b1;
        m_rdy  = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      acc = action_valid && m_rdy;
      if (wena) begin
        m_mem[int'(WR_thread_in) * 32 + int'(WR_addr_in)] = WR_data_in;
      end else if (m_pend.size() > 0) begin
        a = m_pend.pop_front();
        m_write_action(a.t, a.d);
      end else if (acc) begin
        m_write_action(int'(action_thread_id_in), action_data_in);
      end
      if (acc && wena) begin
        a.t = int'(action_thread_id_in);
        a.d = action_data_in;
        m_pend.push_back(a);
      end
      m_rdy = (m_pend.size() == 0);
      if (clear_req) begin
        m_init = 1'b0;
        m_rdy  = 1'b0;
        m_cnt  = 0;
        m_pend.delete();
      end
    end
  endtask

  task automatic step(input int ph, input logic rst, input logic clr,
                      input logic we, input logic [1:0] wt, input logic [4:0] wa,
                      input logic [63:0] wd, input logic av, input logic [1:0] at,
                      input logic [7:0] ad, input logic [1:0] rt,
                      input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n             = rst;
    clear_req           = clr;
    wena                = we;
    WR_thread_in        = wt;
    WR_addr_in          = wa;
    WR_data_in          = wd;
    action_valid        = av;
    action_thread_id_in = at;
    action_data_in      = ad;
    rd_thread_in        = rt;
    R1_addr_in          = a1;
    R2_addr_in          = a2;
    if (!rst) begin
      m_init = 1'b0;
      m_rdy  = 1'b0;
      m_cnt  = 0;
      m_pend.delete();
    end
    e.ph  = ph;
    e.ei  = m_init;
    e.er  = m_rdy;
    e.chk = m_init;
    e.e1  = m_read(int'(rt) * 32 + int'(a1));
    e.e2  = m_read(int'(rt) * 32 + int'(a2));
    sb_q.push_back(e);
    if (rst) model_edge();
  endtask

  task automatic idle(input int ph, input logic [1:0] rt, input logic [4:0] a1,
                      input logic [4:0] a2);
    step(ph, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 64'h0, 1'b0, 2'd0, 8'h0, rt, a1, a2);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total = total + 1;
      if (init_done !== e.ei) begin
        bad = bad + 1;
        $display("FAIL ph%0d init_done got %b want %b", e.ph, init_done, e.ei);
      end
      total = total + 1;
      if (action_ready !== e.er) begin
        bad = bad + 1;
        $display("FAIL ph%0d action_ready got %b want %b", e.ph, action_ready, e.er);
      end
      if (e.chk) begin
        total = total + 1;
        if (R1_data_out !== e.e1) begin
          bad = bad + 1;
          $display("FAIL ph%0d R1_data got %h want %h", e.ph, R1_data_out, e.e1);
        end
        total = total + 1;
        if (R2_data_out !== e.e2) begin
          bad = bad + 1;
          $display("FAIL ph%0d R2_data got %h want %h", e.ph, R2_data_out, e.e2);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; clear_req = 1'b0; wena = 1'b0; WR_thread_in = 2'd0;
    WR_addr_in = 5'd0; WR_data_in = 64'h0; action_valid = 1'b0;
    action_thread_id_in = 2'd0; action_data_in = 8'h0; rd_thread_in = 2'd0;
    R1_addr_in = 5'd0; R2_addr_in = 5'd0;
    m_init = 1'b0; m_rdy = 1'b0; m_cnt = 0;

    // T1: reset, partial sweep, reset mid-sweep, then full 128-cycle sweep.
    for (int i = 0; i < 3; i++)
      step(1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 64'h0, 1'b0, 2'd0, 8'h0, 2'd0, 5'd0, 5'd0);
    for (int i = 0; i < 40; i++) idle(1, 2'd0, 5'd0, 5'd1);
    for (int i = 0; i < 2; i++)
      step(1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 64'h0, 1'b0, 2'd0, 8'h0, 2'd0, 5'd0, 5'd0);
    n = 0;
    while (!m_init && n < 300) begin idle(1, 2'd0, 5'd0, 5'd1); n++; end
    for (int k = 0; k < 64; k++)
      idle(1, 2'(k / 16), 5'((k % 16) * 2), 5'((k % 16) * 2 + 1));

    // T2: write thread 2 index 9, read it back and the same index on thread 1.
    step(2, 1'b1, 1'b0, 1'b1, 2'd2, 5'd9, 64'h0123456789ABCDEF, 1'b0, 2'd0, 8'h0,
         2'd2, 5'd9, 5'd9);
    idle(2, 2'd2, 5'd9, 5'd8);
    idle(2, 2'd1, 5'd9, 5'd9);

    // T3: uncontended action to thread 1.
    step(3, 1'b1, 1'b0, 1'b0, 2'd0, 5'd0, 64'h0, 1'b1, 2'd1, 8'hA5, 2'd1, 5'd7, 5'd6);
    idle(3, 2'd1, 5'd7, 5'd6);

    // T4: action to thread 3 under four cycles of writes.
    step(4, 1'b1, 1'b0, 1'b1, 2'd0, 5'd1, 64'h1111, 1'b1, 2'd3, 8'h3C, 2'd3, 5'd7, 5'd6);
    for (int i = 0; i < 3; i++)
      step(4, 1'b1, 1'b0, 1'b1, 2'd0, 5'(2 + i), {$urandom, $urandom}, 1'b0, 2'd0,
           8'h0, 2'd3, 5'd7, 5'd6);
    idle(4, 2'd3, 5'd7, 5'd6);
    idle(4, 2'd3, 5'd7, 5'd6);

    // T6: write to an entry while read port 2 addresses it.
    step(6, 1'b1, 1'b0, 1'b1, 2'd0, 5'd4, 64'hDEAD, 1'b0, 2'd0, 8'h0, 2'd0, 5'd3, 5'd4);
    step(6, 1'b1, 1'b0, 1'b1, 2'd0, 5'd4, 64'h55, 1'b0, 2'd0, 8'h0, 2'd0, 5'd4, 5'd4);
    idle(6, 2'd0, 5'd4, 5'd4);

    // Random traffic with occasional clears.
    for (int i = 0; i < 1500; i++)
      step(7, 1'b1, ($urandom_range(0, 299) == 0), ($urandom_range(0, 1) == 1),
           2'($urandom), 5'($urandom), {$urandom, $urandom},
           ($urandom_range(0, 9) < 3), 2'($urandom), 8'($urandom),
           2'($urandom), 5'($urandom), 5'($urandom));
    n = 0;
    while (!m_init && n < 300) begin idle(7, 2'd0, 5'd0, 5'd0); n++; end
    for (int i = 0; i < 4; i++) idle(7, 2'd0, 5'd0, 5'd0);

    // T5: clear after a known write, sweep, then the entry reads 0.
    step(5, 1'b1, 1'b0, 1'b1, 2'd2, 5'd9, 64'h0123456789ABCDEF, 1'b0, 2'd0, 8'h0,
         2'd2, 5'd9, 5'd9);
    step(5, 1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 64'h0, 1'b0, 2'd0, 8'h0, 2'd2, 5'd9, 5'd9);
    n = 0;
    while (!m_init && n < 300) begin idle(5, 2'd2, 5'd9, 5'd9); n++; end
    idle(5, 2'd2, 5'd9, 5'd8);

    repeat (2) @(negedge clk);
    #1;
    total = total + 1;
    if (sb_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain pending got %0d want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
